// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO bus controller.
package mmio_pkg;

  // Default widths used by the controller and its decoder.
  localparam int DATA_W = 32;
  localparam int ADDR_W = 21;
  localparam int SLOT_W = 5;

  // Read data returned with every error completion.
  localparam logic [31:0] MMIO_ERR_DATA = 32'hDEAD_BEEF;

  // One bus access walks IDLE -> (ACCESS -> WAIT*)? -> DONE -> IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } mmio_state_e;

endpackage

// File: rtl/mmio_slot_decode.sv
// Combinational address decoder: word address -> slot index, one-hot
// slot select, mapped flag and register offset inside the slot.
module mmio_slot_decode #(
  parameter int ADDR_W    = 21,
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 5,
  parameter int SLOT_LSB  = 5,
  parameter int REG_AW    = 5
) (
  input  logic [ADDR_W-1:0]    bus_addr,
  output logic [SLOT_W-1:0]    slot_idx,
  output logic [NUM_SLOTS-1:0] slot_onehot,
  output logic                 mapped,
  output logic [REG_AW-1:0]    reg_off
);

  assign slot_idx = bus_addr[SLOT_LSB +: SLOT_W];
  assign reg_off  = bus_addr[REG_AW-1:0];

  // Slot field values past the populated slots have no peripheral behind them.
  assign mapped = (32'(slot_idx) < NUM_SLOTS);

  // An unmapped index matches no select line, so the one-hot is all zero.
  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_onehot
      assign slot_onehot[gi] = (slot_idx == SLOT_W'(gi));
    end
  endgenerate

  // Address bits outside the slot and register fields are don't-care.
  generate
    if (ADDR_W > SLOT_LSB + SLOT_W) begin : g_upper_unused
      logic unused_upper_bits;
      assign unused_upper_bits = ^bus_addr[ADDR_W-1:SLOT_LSB+SLOT_W];
    end
    if (SLOT_LSB > REG_AW) begin : g_gap_unused
      logic unused_gap_bits;
      assign unused_gap_bits = ^bus_addr[SLOT_LSB-1:REG_AW];
    end
  endgenerate

endmodule

// File: rtl/mmio_bus_ctrl.sv
// MMIO bus sequencer: turns one CPU MMIO request into a single-cycle slot
// strobe, waits for that slot's ack (bounded by TIMEOUT) and completes the
// CPU access with a one-cycle ready pulse, flagging errors on bus_err.
module mmio_bus_ctrl
  import mmio_pkg::mmio_state_e, mmio_pkg::IDLE, mmio_pkg::ACCESS,
         mmio_pkg::WAIT, mmio_pkg::DONE, mmio_pkg::MMIO_ERR_DATA;
#(
  parameter int ADDR_W    = mmio_pkg::ADDR_W,
  parameter int DATA_W    = mmio_pkg::DATA_W,
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = mmio_pkg::SLOT_W,
  parameter int SLOT_LSB  = 5,
  parameter int REG_AW    = 5,
  parameter int TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          reset_in,
  input  logic                          bus_cs,
  input  logic                          bus_wr,
  input  logic                          bus_rd,
  input  logic [ADDR_W-1:0]             bus_addr,
  input  logic [DATA_W-1:0]             bus_wr_data,
  output logic [DATA_W-1:0]             bus_rd_data,
  output logic                          bus_ready,
  output logic                          bus_err,
  output logic [NUM_SLOTS-1:0]          slot_cs,
  output logic                          slot_wr,
  output logic                          slot_rd,
  output logic [REG_AW-1:0]             slot_addr,
  output logic [DATA_W-1:0]             slot_wr_data,
  input  logic [NUM_SLOTS*DATA_W-1:0]   slot_rd_data,
  input  logic [NUM_SLOTS-1:0]          slot_ack
);

  mmio_state_e           state_reg, state_next;
  logic [NUM_SLOTS-1:0]  sel_reg;
  logic [REG_AW-1:0]     reg_off_reg;
  logic                  wr_reg;
  logic [DATA_W-1:0]     wdata_reg;
  logic [DATA_W-1:0]     rdata_reg;
  logic                  err_reg;
  logic [15:0]           cnt_reg;

  logic [SLOT_W-1:0]     dec_slot_idx_unused;
  logic [NUM_SLOTS-1:0]  dec_onehot;
  logic                  dec_mapped;
  logic [REG_AW-1:0]     dec_reg_off;
  logic                  req_ok;
  logic                  ack_sel;
  logic                  timeout_hit;
  logic [DATA_W-1:0]     rd_mux;
  logic [DATA_W-1:0]     slot_word [NUM_SLOTS];

  mmio_slot_decode #(
    .ADDR_W    (ADDR_W),
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W),
    .SLOT_LSB  (SLOT_LSB),
    .REG_AW    (REG_AW)
  ) u_decode (
    .bus_addr    (bus_addr),
    .slot_idx    (dec_slot_idx_unused),
    .slot_onehot (dec_onehot),
    .mapped      (dec_mapped),
    .reg_off     (dec_reg_off)
  );

  // A request goes to a slot only if mapped and exactly one of wr/rd is set.
  assign req_ok      = dec_mapped && (bus_wr ^ bus_rd);
  // Only the selected slot may complete the access.
  assign ack_sel     = |(slot_ack & sel_reg);
  assign timeout_hit = (cnt_reg == 16'(TIMEOUT - 1));

  // Mask every slot's read word with its select bit so the mux is a plain OR.
  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_rd_word
      assign slot_word[gi] = slot_rd_data[gi*DATA_W +: DATA_W] & {DATA_W{sel_reg[gi]}};
    end
  endgenerate

  // OR-reduce the masked slot words into the captured read value.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      rd_mux = rd_mux | slot_word[i];
    end
  end

  // Next-state and output decode; every output is zero unless its state drives it.
  always_comb begin
    state_next   = state_reg;
    slot_cs      = '0;
    slot_wr      = 1'b0;
    slot_rd      = 1'b0;
    slot_addr    = '0;
    slot_wr_data = '0;
    bus_ready    = 1'b0;
    bus_err      = 1'b0;
    bus_rd_data  = '0;
    case (state_reg)
      IDLE: begin
        if (bus_cs) begin
          state_next = req_ok ? ACCESS : DONE;
        end
      end
      ACCESS: begin
        slot_cs      = sel_reg;
        slot_wr      = wr_reg;
        slot_rd      = !wr_reg;
        slot_addr    = reg_off_reg;
        slot_wr_data = wdata_reg;
        state_next   = ack_sel ? DONE : WAIT;
      end
      WAIT: begin
        slot_addr    = reg_off_reg;
        slot_wr_data = wdata_reg;
        if (ack_sel || timeout_hit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus_ready  = 1'b1;
        bus_err    = err_reg;
        if (err_reg) begin
          bus_rd_data = DATA_W'(MMIO_ERR_DATA);
        end else if (!wr_reg) begin
          bus_rd_data = rdata_reg;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, request capture, wait counter and read-data capture.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_reg   <= IDLE;
      sel_reg     <= '0;
      reg_off_reg <= '0;
      wr_reg      <= 1'b0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (bus_cs) begin
            sel_reg     <= dec_onehot;
            reg_off_reg <= dec_reg_off;
            wr_reg      <= bus_wr;
            wdata_reg   <= bus_wr_data;
            err_reg     <= !req_ok;
            cnt_reg     <= '0;
          end
        end
        ACCESS: begin
          if (ack_sel) begin
            rdata_reg <= rd_mux;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg + 16'd1;
          if (ack_sel) begin
            rdata_reg <= rd_mux;
          end else if (timeout_hit) begin
            err_reg <= 1'b1;
          end
        end
        DONE: begin
          cnt_reg <= '0;
          err_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
